dac_pulse_player: RTL

//  Pulse-playback stage directly upstream of the DAC AXI-Stream master.

---
 rtl/dac_pulse_player.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dac_pulse_player.sv
// rtl/dac_pulse_player.sv - pulse playback from waveform RAM with Q1.15 gain into the DAC sample stream
//
// Purpose: accepts pulse commands (start address, length, gain) over a
// valid/ready handshake, reads packed I/Q envelope samples from a
// synchronous-read waveform RAM, scales each lane by a signed Q1.15 gain with
// saturation and emits one sample per clock with no backpressure.
//
// Ports:
//   clk, rst                    sole clock; asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_addr/cmd_len/cmd_gain   first RAM address, sample count, Q1.15 gain
//   abort                       drops the current pulse, effective next cycle
//   mem_en/mem_addr/mem_rdata   RAM read port, data valid 1 cycle after mem_en
//   iq_sample/valid_iq          scaled {I,Q}; zero whenever valid_iq is low
//   busy                        first RAM read through last sample out
//   pulse_done                  strobe on the final valid_iq of a pulse
module dac_pulse_player #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [15:0]       cmd_gain,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       iq_sample,
  output logic              valid_iq,
  output logic              busy,
  output logic              pulse_done
);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       gain_q, gain_d;
  logic              drain_q, drain_d;     // set during the second DRAIN cycle
  logic              rd_vld_q, rd_vld_d;   // RAM data on mem_rdata this cycle
  logic              rd_last_q, rd_last_d; // that data is the final sample
  logic              out_vld_q, out_vld_d;
  logic              done_q, done_d;
  logic [31:0]       out_q, out_d;

  logic accept;
  logic play_last;

  // r = (x*g) >>> 15, clamped to 16-bit signed. Only -1.0 * -1.0 can overflow.
  function automatic logic [15:0] scale_sat(input logic [15:0] x, input logic [15:0] g);
    logic signed [31:0] xe, ge, p, r;
    xe = {{16{x[15]}}, x};
    ge = {{16{g[15]}}, g};
    p  = xe * ge;
    r  = p >>> 15;
    if (r > 32'sd32767)       scale_sat = 16'h7FFF;
    else if (r < -32'sd32768) scale_sat = 16'h8000;
    else                      scale_sat = r[15:0];
  endfunction

  assign cmd_ready  = (state_q == IDLE) && !rst;
  assign mem_en     = (state_q == PLAY);
  assign mem_addr   = mem_en ? (addr_q + ADDR_W'(cnt_q)) : '0;
  assign busy       = (state_q != IDLE);
  assign iq_sample  = out_q;
  assign valid_iq   = out_vld_q;
  assign pulse_done = done_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gain_d    = gain_q;
    drain_d   = drain_q;

    // Abort beats a concurrent handshake: the command is simply not taken.
    accept    = cmd_valid && (state_q == IDLE) && !abort;
    play_last = (state_q == PLAY) && (cnt_q == len_q - LEN_W'(1));

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          gain_d = cmd_gain;
          cnt_d  = '0;
          if (cmd_len != '0) state_d = PLAY;
        end
      end
      PLAY: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (play_last) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = !drain_q;
        if (drain_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Stage 1 tracks the RAM read in flight; stage 2 scales into the output.
    rd_vld_d  = mem_en;
    rd_last_d = play_last;
    out_vld_d = rd_vld_q;
    out_d     = rd_vld_q ? {scale_sat(mem_rdata[31:16], gain_q),
                            scale_sat(mem_rdata[15:0], gain_q)} : 32'h0;
    // A zero-length pulse completes immediately with no samples.
    done_d    = (rd_vld_q && rd_last_q) || (accept && (cmd_len == '0));

    if (abort) begin
      state_d   = IDLE;
      drain_d   = 1'b0;
      rd_vld_d  = 1'b0;
      rd_last_d = 1'b0;
      out_vld_d = 1'b0;
      out_d     = 32'h0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      gain_q    <= '0;
      drain_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      gain_q    <= gain_d;
      drain_q   <= drain_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      out_vld_q <= out_vld_d;
      done_q    <= done_d;
      out_q     <= out_d;
    end
  end

endmodule
